// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
//   Shared definitions for the data-memory arbiter: default bus widths,
//   requester indices and the ownership state type.
package dmem_arb_pkg;
    localparam int DMEM_ADDR_W = 5;
    localparam int DMEM_DATA_W = 8;
    localparam int NUM_REQ     = 2;

    localparam int REQ_CPU = 0;
    localparam int REQ_DBG = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;
endpackage

// File: rtl/dmem_arb_wait_cnt.sv
// dmem_arb_wait_cnt
//   Saturating wait counter for one requester. Counts cycles spent requesting
//   without a grant; raises o_starve once MAX_WAIT is reached.
// Ports
//   i_clk     clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_req     requester is asking this cycle
//   i_gnt     requester is granted this cycle
//   o_starve  counter has reached MAX_WAIT
module dmem_arb_wait_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_starve
);
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (!i_req || i_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != CW'(MAX_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_starve = (r_cnt == CW'(MAX_WAIT));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU (requester 0) and the
//   debug/loader port (requester 1). Grants combinationally, registers the
//   winning access onto the memory bus, and routes read data back with a
//   registered owner tag (rvalid two cycles after grant).
//   Build option: define DMEM_ARB_RR_EN for a round-robin tie break;
//   otherwise the CPU wins every tie. Starvation and lock rules apply always.
// Ports
//   i_clk, i_reset          clock / async active-high reset
//   i_req, i_lock, i_we     per-requester request, ownership lock, write flag
//   i_addr0/1, i_wdata0/1   per-requester address and write data
//   o_gnt                   combinational grant (one-hot or zero)
//   o_rvalid                read data valid, per requester
//   o_rdata                 read data, pass-through of i_mem_rdata
//   o_mem_addr/_read/_write/_wdata  registered memory bus
//   i_mem_rdata             memory read data, one cycle after o_mem_read
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_lock,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_gnt,
    output logic [1:0]        o_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    owner_t              r_owner;
    logic                r_tag;
    logic [1:0]          w_gnt;
    logic [1:0]          w_starve;
    logic                w_sel;
    logic                w_we;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
        dmem_arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_wait (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_req    (i_req[g]),
            .i_gnt    (w_gnt[g]),
            .o_starve (w_starve[g])
        );
    end

`ifdef DMEM_ARB_RR_EN
    // 1 = debug was granted last, so the CPU wins the next tie.
    logic r_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_last <= 1'b1;
        else if (|w_gnt)
            r_last <= w_gnt[REQ_DBG];
    end
`endif

    // Starving requester first, then lock owner, then base policy.
    always_comb begin
        w_gnt = 2'b00;
        if (!i_reset) begin
            if (w_starve[REQ_CPU] && i_req[REQ_CPU]) begin
                w_gnt = 2'b01;
            end else if (w_starve[REQ_DBG] && i_req[REQ_DBG]) begin
                w_gnt = 2'b10;
            end else if (r_owner == OWN_CPU) begin
                w_gnt[REQ_CPU] = i_req[REQ_CPU];
            end else if (r_owner == OWN_DBG) begin
                w_gnt[REQ_DBG] = i_req[REQ_DBG];
            end else begin
`ifdef DMEM_ARB_RR_EN
                if (i_req == 2'b11)
                    w_gnt = r_last ? 2'b01 : 2'b10;
                else
                    w_gnt = i_req;
`else
                if (i_req[REQ_CPU])
                    w_gnt = 2'b01;
                else if (i_req[REQ_DBG])
                    w_gnt = 2'b10;
`endif
            end
        end
    end

    assign w_sel   = w_gnt[REQ_DBG];
    assign w_we    = w_sel ? i_we[REQ_DBG] : i_we[REQ_CPU];
    assign w_addr  = w_sel ? i_addr1  : i_addr0;
    assign w_wdata = w_sel ? i_wdata1 : i_wdata0;

    // Owner FSM plus the registered memory bus and read-return tag.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_owner     <= IDLE;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            r_tag       <= 1'b0;
            o_rvalid    <= 2'b00;
        end else begin
            case (r_owner)
                IDLE: begin
                    if (w_gnt[REQ_CPU] && i_lock[REQ_CPU])
                        r_owner <= OWN_CPU;
                    else if (w_gnt[REQ_DBG] && i_lock[REQ_DBG])
                        r_owner <= OWN_DBG;
                end
                // A grant to the other side here can only come from starvation.
                OWN_CPU: begin
                    if (!i_req[REQ_CPU] || w_gnt[REQ_DBG] ||
                        (w_gnt[REQ_CPU] && !i_lock[REQ_CPU]))
                        r_owner <= IDLE;
                end
                OWN_DBG: begin
                    if (!i_req[REQ_DBG] || w_gnt[REQ_CPU] ||
                        (w_gnt[REQ_DBG] && !i_lock[REQ_DBG]))
                        r_owner <= IDLE;
                end
                default: r_owner <= IDLE;
            endcase

            o_mem_read  <= (|w_gnt) && !w_we;
            o_mem_write <= (|w_gnt) && w_we;
            if (|w_gnt) begin
                o_mem_addr <= w_addr;
                r_tag      <= w_sel;
                if (w_we)
                    o_mem_wdata <= w_wdata;
            end

            o_rvalid <= o_mem_read ? (r_tag ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign o_gnt   = w_gnt;
    assign o_rdata = i_mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req, lock, we;
    logic [4:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata, mwd, mrdata;
    logic [4:0] maddr;
    logic       mrd, mwr;
    logic [7:0] mem [32];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(8), .MAX_WAIT(8)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (req),
        .i_lock      (lock),
        .i_we        (we),
        .i_addr0     (a0),
        .i_addr1     (a1),
        .i_wdata0    (d0),
        .i_wdata1    (d1),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_addr  (maddr),
        .o_mem_read  (mrd),
        .o_mem_write (mwr),
        .o_mem_wdata (mwd),
        .i_mem_rdata (mrdata)
    );

    // Behavioural single-port memory, read data one cycle after the strobe.
    initial begin
        for (int k = 0; k < 32; k++) mem[k] = 8'h00;
        mrdata = 8'h00;
    end
    always @(posedge clk) begin
        if (mrd) mrdata <= mem[maddr];
        if (mwr) mem[maddr] <= mwd;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [4:0] x0, input logic [7:0] y0,
                       input logic [4:0] x1, input logic [7:0] y1);
        req = r; lock = l; we = w; a0 = x0; d0 = y0; a1 = x1; d1 = y1;
    endtask

    // CPU write then read of one address, checking full bus timing.
    task automatic cpu_wr_rd(input string t, input logic [4:0] ad, input logic [7:0] dv);
        drv(2'b01, 2'b00, 2'b01, ad, dv, 5'd0, 8'h00);
        @(negedge clk); chk({t, "_wgnt"}, gnt, 2'b01);
        nxt;
        drv(2'b01, 2'b00, 2'b00, ad, 8'h00, 5'd0, 8'h00);
        @(negedge clk);
        chk({t, "_rgnt"}, gnt, 2'b01);
        chk({t, "_mwr"}, mwr, 1'b1);
        chk({t, "_mrd0"}, mrd, 1'b0);
        chk({t, "_maddr"}, maddr, ad);
        chk({t, "_mwd"}, mwd, dv);
        nxt;
        drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        @(negedge clk);
        chk({t, "_mrd"}, mrd, 1'b1);
        chk({t, "_mwr0"}, mwr, 1'b0);
        chk({t, "_rv_wr"}, rvalid, 2'b00);
        nxt;
        @(negedge clk);
        chk({t, "_rv"}, rvalid, 2'b01);
        chk({t, "_rdata"}, rdata, dv);
        chk({t, "_idle_rd"}, mrd, 1'b0);
        chk({t, "_addr_hold"}, maddr, ad);
        nxt;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    logic [1:0] hist [20];
    logic [1:0] eg;
    int         dc;
    bit         cdone;

    initial begin
        rst = 1'b1;
        drv(2'b11, 2'b11, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_mrd", mrd, 1'b0);
        chk("rst_mwr", mwr, 1'b0);
        chk("rst_maddr", maddr, 5'd0);
        chk("rst_mwd", mwd, 8'h00);
        @(posedge clk); #1;
        drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        rst = 1'b0;
        nxt;

        // Test 1: CPU write/read addr 3.
        cpu_wr_rd("t1", 5'd3, 8'h5A);

        // Test 6: debug writes addr 7, CPU reads it the next cycle.
        drv(2'b10, 2'b00, 2'b10, 5'd0, 8'h00, 5'd7, 8'hC3);
        @(negedge clk); chk("t6_dgnt", gnt, 2'b10);
        nxt;
        drv(2'b01, 2'b00, 2'b00, 5'd7, 8'h00, 5'd0, 8'h00);
        @(negedge clk);
        chk("t6_cgnt", gnt, 2'b01);
        chk("t6_mwr", mwr, 1'b1);
        chk("t6_mwd", mwd, 8'hC3);
        nxt;
        drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        nxt;
        @(negedge clk);
        chk("t6_rv", rvalid, 2'b01);
        chk("t6_rdata", rdata, 8'hC3);
        nxt;

        // Test 4a: debug locked burst of 4 writes with CPU waiting.
        drv(2'b10, 2'b10, 2'b10, 5'd3, 8'h00, 5'd8, 8'h20);
        @(negedge clk); chk("t4a_g0", gnt, 2'b10);
        nxt;
        drv(2'b11, 2'b10, 2'b10, 5'd3, 8'h00, 5'd9, 8'h21);
        @(negedge clk);
        chk("t4a_g1", gnt, 2'b10);
        chk("t4a_maddr", maddr, 5'd8);
        chk("t4a_mwd", mwd, 8'h20);
        nxt;
        drv(2'b11, 2'b10, 2'b10, 5'd3, 8'h00, 5'd10, 8'h22);
        @(negedge clk); chk("t4a_g2", gnt, 2'b10);
        nxt;
        drv(2'b11, 2'b00, 2'b10, 5'd3, 8'h00, 5'd11, 8'h23);
        @(negedge clk); chk("t4a_g3", gnt, 2'b10);
        nxt;
        drv(2'b11, 2'b00, 2'b10, 5'd3, 8'h00, 5'd12, 8'h24);
        @(negedge clk); chk("t4a_cpu", gnt, 2'b01);
        nxt;
        drv(2'b10, 2'b00, 2'b10, 5'd0, 8'h00, 5'd12, 8'h24);
        @(negedge clk); chk("t4a_dbg", gnt, 2'b10);
        nxt;
        drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        @(negedge clk);
        chk("t4a_rv", rvalid, 2'b01);
        chk("t4a_rdata", rdata, 8'h5A);
        nxt;
        nxt;

        // Tests 2/3: both read continuously, no lock.
        for (int i = 0; i < 20; i++) begin
            if (i < 18) begin
                drv(2'b11, 2'b00, 2'b00, 5'd3, 8'h00, 5'd7, 8'h00);
`ifdef DMEM_ARB_RR_EN
                eg = (i % 2 == 1) ? 2'b10 : 2'b01;
`else
                eg = (i % 9 == 8) ? 2'b10 : 2'b01;
`endif
            end else begin
                drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
                eg = 2'b00;
            end
            hist[i] = eg;
            @(negedge clk);
            chk($sformatf("t2_gnt%0d", i), gnt, eg);
            if (i >= 2) begin
                chk($sformatf("t2_rv%0d", i), rvalid, hist[i-2]);
                if (hist[i-2] != 2'b00)
                    chk($sformatf("t2_rd%0d", i), rdata, hist[i-2][1] ? 8'hC3 : 8'h5A);
            end
            nxt;
        end

        // Test 4b: locked burst of 12; CPU breaks in after 8 waits.
        dc = 0;
        cdone = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drv({dc < 12, (i >= 1) && !cdone}, {dc < 11, 1'b0}, 2'b10,
                5'd3, 8'h00, 5'(16 + dc), 8'(8'h40 + dc));
            eg = (i == 9) ? 2'b01 : 2'b10;
            @(negedge clk);
            chk($sformatf("t4b_gnt%0d", i), gnt, eg);
            if (i == 11) begin
                chk("t4b_rv", rvalid, 2'b01);
                chk("t4b_rdata", rdata, 8'h5A);
            end
            nxt;
            if (eg[1]) dc++;
            if (eg[0]) cdone = 1'b1;
        end
        drv(2'b01, 2'b00, 2'b00, 5'd24, 8'h00, 5'd0, 8'h00);
        @(negedge clk); chk("t4b_rdgnt", gnt, 2'b01);
        nxt;
        drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        nxt;
        @(negedge clk);
        chk("t4b_burst_rv", rvalid, 2'b01);
        chk("t4b_burst_data", rdata, 8'h48);
        nxt;

        // Test 5: reset one cycle after a CPU read grant.
        drv(2'b01, 2'b00, 2'b00, 5'd3, 8'h00, 5'd0, 8'h00);
        @(negedge clk); chk("t5_gnt", gnt, 2'b01);
        nxt;
        drv(2'b00, 2'b00, 2'b00, 5'd0, 8'h00, 5'd0, 8'h00);
        chk("t5_mrd_pre", mrd, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_mrd_rst", mrd, 1'b0);
        chk("t5_mwr_rst", mwr, 1'b0);
        chk("t5_maddr_rst", maddr, 5'd0);
        nxt;
        @(negedge clk);
        chk("t5_no_rv", rvalid, 2'b00);
        nxt;
        rst = 1'b0;
        nxt;
        cpu_wr_rd("t5b", 5'd5, 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
